// File: rtl/sc_dot_product_ctrl_if.sv
// ---------------------------------------------------------------------------
// sc_dot_product_ctrl_if
// Bundles every non-clock, non-reset signal of the stochastic dot-product
// sequencer so the controller and its driver share one declaration.
//
// Parameters
//   WIDTH       operand bit width (also log2 of the result stream length)
//   DIMENSION   vector length
//
// Signals
//   start, abort            run control from the host
//   datas, weights          binary operand vectors, element d at [d*WIDTH +: WIDTH]
//   op_datas, op_weights    operands latched for the SNG bank
//   src_enable, src_restart control of the LFSRs and adder select counter
//   dp_valid, dp_result     incoming stochastic dot-product stream
//   busy, done, error       run status
//   ones_count, dot_product result of the last completed run
//
// Modports
//   slave  : the controller's view
//   master : the host / stream source view
// ---------------------------------------------------------------------------
interface sc_dot_product_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int DIMENSION = 4
);

  localparam int VEC_W = WIDTH * DIMENSION;
  localparam int DP_W  = 2 * WIDTH + 1 + $clog2(DIMENSION);

  logic             start;
  logic             abort;
  logic [VEC_W-1:0] datas;
  logic [VEC_W-1:0] weights;
  logic [VEC_W-1:0] op_datas;
  logic [VEC_W-1:0] op_weights;
  logic             src_enable;
  logic             src_restart;
  logic             dp_valid;
  logic             dp_result;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH:0]   ones_count;
  logic [DP_W-1:0]  dot_product;

  modport slave (
    input  start, abort, datas, weights, dp_valid, dp_result,
    output op_datas, op_weights, src_enable, src_restart,
           busy, done, error, ones_count, dot_product
  );

  modport master (
    output start, abort, datas, weights, dp_valid, dp_result,
    input  op_datas, op_weights, src_enable, src_restart,
           busy, done, error, ones_count, dot_product
  );

endinterface

// File: rtl/sc_dot_product_ctrl.sv
// ---------------------------------------------------------------------------
// sc_dot_product_ctrl
// Sequencer for one stochastic dot-product evaluation. On an accepted start
// it latches the binary data/weight vectors for the SNG bank, restarts and
// enables the LFSRs and adder select counter, waits for the dot-product
// stream to become valid, counts the ones in STREAM_LEN valid result bits and
// reports the count together with the rescaled binary dot product.
//
// Parameters
//   WIDTH       operand bit width; stream length is 2**WIDTH
//   DIMENSION   vector length (power of two, >= 2)
//   STREAM_LEN  valid result bits sampled per run (equals 2**WIDTH)
//   VALID_TMO   cycles allowed in WAIT without dp_valid before error
//
// Ports
//   clk    clock
//   rst    synchronous active-high reset
//   bus    sc_dot_product_ctrl_if.slave:
//            start/abort in, datas/weights in, op_datas/op_weights out,
//            src_enable/src_restart out, dp_valid/dp_result in,
//            busy/done/error out, ones_count/dot_product out
//
// Run sequence: IDLE -> LOAD -> WAIT -> STREAM -> DONE -> IDLE.
// With no stalls, done rises 2 + W + STREAM_LEN cycles after start is
// sampled, W being the number of WAIT cycles without dp_valid.
// ---------------------------------------------------------------------------
module sc_dot_product_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DIMENSION  = 4,
  parameter int STREAM_LEN = 256,
  parameter int VALID_TMO  = 16
) (
  input logic                  clk,
  input logic                  rst,
  sc_dot_product_ctrl_if.slave bus
);

  localparam int CNT_W  = WIDTH + 1;
  localparam int TMO_W  = $clog2(VALID_TMO + 1);
  localparam int ZERO_W = WIDTH + $clog2(DIMENSION);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(STREAM_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(VALID_TMO - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [TMO_W-1:0] wait_cnt;

  // Single registered FSM. Every output is a register updated on the
  // transition into the state that owns it, so done/busy/src_* never glitch.
  // abort is only honoured in LOAD, WAIT and STREAM; in IDLE a simultaneous
  // start simply wins because abort is never looked at there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      sample_cnt      <= '0;
      ones_cnt        <= '0;
      wait_cnt        <= '0;
      bus.op_datas    <= '0;
      bus.op_weights  <= '0;
      bus.src_enable  <= 1'b0;
      bus.src_restart <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.ones_count  <= '0;
      bus.dot_product <= '0;
    end else begin
      bus.done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.op_datas    <= bus.datas;
            bus.op_weights  <= bus.weights;
            bus.error       <= 1'b0;
            bus.busy        <= 1'b1;
            bus.src_restart <= 1'b1;
            bus.src_enable  <= 1'b1;
            state           <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (bus.abort) begin
            bus.busy        <= 1'b0;
            bus.src_enable  <= 1'b0;
            bus.src_restart <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            bus.src_restart <= 1'b0;
            sample_cnt      <= '0;
            ones_cnt        <= '0;
            wait_cnt        <= '0;
            state           <= ST_WAIT;
          end
        end

        // The cycle in which dp_valid first rises already carries the first
        // stream bit, so it is counted here rather than in STREAM.
        ST_WAIT: begin
          if (bus.abort) begin
            bus.busy       <= 1'b0;
            bus.src_enable <= 1'b0;
            state          <= ST_IDLE;
          end else if (bus.dp_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_cnt + CNT_W'(bus.dp_result);
            state      <= ST_STREAM;
          end else if (wait_cnt == TMO_LAST) begin
            bus.error      <= 1'b1;
            bus.busy       <= 1'b0;
            bus.src_enable <= 1'b0;
            state          <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Stalls (dp_valid low) just hold the counters; there is no timeout
        // once the stream has started.
        ST_STREAM: begin
          if (bus.abort) begin
            bus.busy       <= 1'b0;
            bus.src_enable <= 1'b0;
            state          <= ST_IDLE;
          end else if (bus.dp_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_cnt + CNT_W'(bus.dp_result);
            if (sample_cnt == SAMPLE_LAST) begin
              bus.src_enable <= 1'b0;
              state          <= ST_DONE;
            end
          end
        end

        // Publish results. The dot product is the ones count scaled by
        // DIMENSION * 2**WIDTH, which is a pure left shift.
        ST_DONE: begin
          bus.ones_count  <= ones_cnt;
          bus.dot_product <= {ones_cnt, {ZERO_W{1'b0}}};
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= ST_IDLE;
        end

        default: begin
          bus.busy        <= 1'b0;
          bus.src_enable  <= 1'b0;
          bus.src_restart <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_dot_product_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_dot_product_ctrl
// Self-checking bench for sc_dot_product_ctrl. Stream stimulus is held in
// queues (one entry per cycle from the first WAIT cycle onward); a small
// reference model derives the expected ones count and done cycle from those
// queues.
// ---------------------------------------------------------------------------
module tb_sc_dot_product_ctrl;

  localparam int WIDTH      = 8;
  localparam int DIMENSION  = 4;
  localparam int STREAM_LEN = 256;
  localparam int VALID_TMO  = 16;
  localparam int VEC_W      = WIDTH * DIMENSION;
  localparam int DP_W       = 2 * WIDTH + 1 + $clog2(DIMENSION);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sc_dot_product_ctrl_if #(.WIDTH(WIDTH), .DIMENSION(DIMENSION)) bus ();

  sc_dot_product_ctrl #(
    .WIDTH     (WIDTH),
    .DIMENSION (DIMENSION),
    .STREAM_LEN(STREAM_LEN),
    .VALID_TMO (VALID_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Stream stimulus: entry i is applied at the i-th edge after LOAD.
  bit validQ[$];
  bit resultQ[$];

  // Observations of the last drive_run.
  int               obsDoneEdge;
  int               obsDoneCount;
  int               obsRestartCount;
  int               obsBusyLow;
  logic [WIDTH:0]   obsOnes;
  logic [DP_W-1:0]  obsDot;
  logic [VEC_W-1:0] obsOpD;
  logic [VEC_W-1:0] obsOpW;
  logic             obsErrAfterStart;

  int lastOnes;

  // Reference model: edge count (after the start edge) at which done is
  // seen, i.e. one cycle after the STREAM_LEN-th valid sample.
  function automatic int model_done_edge();
    int cnt = 0;
    for (int i = 0; i < validQ.size(); i++) begin
      if (validQ[i]) begin
        cnt++;
        if (cnt == STREAM_LEN) return i + 3;
      end
    end
    return -1;
  endfunction

  // Reference model: ones among the first STREAM_LEN valid samples.
  function automatic int model_ones();
    int cnt = 0;
    int ones = 0;
    for (int i = 0; i < validQ.size(); i++) begin
      if (validQ[i] && cnt < STREAM_LEN) begin
        cnt++;
        ones += int'(resultQ[i]);
      end
    end
    return ones;
  endfunction

  function automatic logic [DP_W-1:0] model_dot(input int ones);
    longint v;
    v = longint'(ones) * DIMENSION * (longint'(1) << WIDTH);
    return DP_W'(v);
  endfunction

  // Starts a run and plays validQ/resultQ, recording what the DUT did.
  task automatic drive_run(input logic [VEC_W-1:0] d, input logic [VEC_W-1:0] w);
    int total;
    int idx;
    bus.datas     = d;
    bus.weights   = w;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.dp_valid  = 1'b0;
    bus.dp_result = 1'b0;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    obsDoneEdge      = -1;
    obsDoneCount     = 0;
    obsBusyLow       = -1;
    obsRestartCount  = (bus.src_restart === 1'b1) ? 1 : 0;
    obsOpD           = bus.op_datas;
    obsOpW           = bus.op_weights;
    obsErrAfterStart = bus.error;
    obsOnes          = '0;
    obsDot           = '0;
    total = validQ.size() + 6;
    for (int k = 1; k <= total; k++) begin
      idx = k - 2;
      if (idx >= 0 && idx < validQ.size()) begin
        bus.dp_valid  = validQ[idx];
        bus.dp_result = resultQ[idx];
      end else begin
        bus.dp_valid  = 1'b0;
        bus.dp_result = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.src_restart === 1'b1) obsRestartCount++;
      if (bus.busy !== 1'b1 && obsBusyLow < 0) obsBusyLow = k;
      if (bus.done === 1'b1) begin
        if (obsDoneEdge < 0) begin
          obsDoneEdge = k;
          obsOnes     = bus.ones_count;
          obsDot      = bus.dot_product;
        end
        obsDoneCount++;
      end
    end
    bus.dp_valid  = 1'b0;
    bus.dp_result = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.datas     = '0;
    bus.weights   = '0;
    bus.dp_valid  = 1'b0;
    bus.dp_result = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.src_enable, bus.src_restart} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.busy, bus.done, bus.error, bus.src_enable, bus.src_restart});
    end
    checks++;
    if (bus.ones_count !== '0 || bus.dot_product !== '0) begin
      errors++;
      $display("[TB] FAIL reset_results: got ones=%0d dot=%0d expected 0/0", bus.ones_count, bus.dot_product);
    end
    checks++;
    if (bus.op_datas !== '0 || bus.op_weights !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ops: got %h/%h expected 0/0", bus.op_datas, bus.op_weights);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ones();
    int expEdge;
    int expOnes;
    validQ.delete();
    resultQ.delete();
    for (int i = 0; i < STREAM_LEN; i++) begin
      validQ.push_back(1'b1);
      resultQ.push_back(1'b1);
    end
    expEdge = model_done_edge();
    expOnes = model_ones();
    drive_run(32'h0F0F0F0F, 32'h0A0A0A0A);
    checks++;
    if (obsOpD !== 32'h0F0F0F0F || obsOpW !== 32'h0A0A0A0A) begin
      errors++;
      $display("[TB] FAIL ones_ops: got %h/%h expected 0f0f0f0f/0a0a0a0a", obsOpD, obsOpW);
    end
    checks++;
    if (obsRestartCount !== 1) begin
      errors++;
      $display("[TB] FAIL ones_restart: got %0d pulses expected 1", obsRestartCount);
    end
    checks++;
    if (obsDoneEdge !== expEdge || obsDoneCount !== 1) begin
      errors++;
      $display("[TB] FAIL ones_done: got edge %0d width %0d expected edge %0d width 1",
               obsDoneEdge, obsDoneCount, expEdge);
    end
    checks++;
    if (obsOnes !== 9'(expOnes) || obsDot !== model_dot(expOnes)) begin
      errors++;
      $display("[TB] FAIL ones_result: got %0d/%0d expected %0d/%0d",
               obsOnes, obsDot, expOnes, model_dot(expOnes));
    end
    checks++;
    if (obsBusyLow !== expEdge) begin
      errors++;
      $display("[TB] FAIL ones_busy: got low at %0d expected %0d", obsBusyLow, expEdge);
    end
    lastOnes = expOnes;
  endtask

  task automatic test_alternating();
    int w;
    int expOnes;
    logic [VEC_W-1:0] d;
    logic [VEC_W-1:0] wt;
    validQ.delete();
    resultQ.delete();
    w = $urandom_range(1, 8);
    for (int i = 0; i < w; i++) begin
      validQ.push_back(1'b0);
      resultQ.push_back(1'b1);
    end
    for (int i = 0; i < STREAM_LEN; i++) begin
      validQ.push_back(1'b1);
      resultQ.push_back((i % 2) == 0);
    end
    expOnes = model_ones();
    d  = $urandom;
    wt = $urandom;
    drive_run(d, wt);
    checks++;
    if (obsDoneEdge !== 2 + w + STREAM_LEN) begin
      errors++;
      $display("[TB] FAIL alt_latency: got %0d expected %0d", obsDoneEdge, 2 + w + STREAM_LEN);
    end
    checks++;
    if (obsOnes !== 9'(expOnes) || obsDot !== model_dot(expOnes)) begin
      errors++;
      $display("[TB] FAIL alt_result: got %0d/%0d expected %0d/%0d",
               obsOnes, obsDot, expOnes, model_dot(expOnes));
    end
    checks++;
    if (obsOpD !== d || obsOpW !== wt) begin
      errors++;
      $display("[TB] FAIL alt_ops: got %h/%h expected %h/%h", obsOpD, obsOpW, d, wt);
    end
    lastOnes = expOnes;
  endtask

  task automatic test_stall();
    int w;
    int expOnes;
    validQ.delete();
    resultQ.delete();
    w = 2;
    for (int i = 0; i < w; i++) begin
      validQ.push_back(1'b0);
      resultQ.push_back(1'b0);
    end
    for (int i = 0; i < STREAM_LEN + 10; i++) begin
      if (i >= 100 && i < 110) begin
        validQ.push_back(1'b0);
        resultQ.push_back(1'b1);
      end else begin
        validQ.push_back(1'b1);
        resultQ.push_back((i % 2) == 0);
      end
    end
    expOnes = model_ones();
    drive_run($urandom, $urandom);
    checks++;
    if (obsDoneEdge !== 2 + w + STREAM_LEN + 10) begin
      errors++;
      $display("[TB] FAIL stall_latency: got %0d expected %0d", obsDoneEdge, 2 + w + STREAM_LEN + 10);
    end
    checks++;
    if (obsOnes !== 9'(expOnes) || obsDot !== model_dot(expOnes)) begin
      errors++;
      $display("[TB] FAIL stall_result: got %0d/%0d expected %0d/%0d",
               obsOnes, obsDot, expOnes, model_dot(expOnes));
    end
    lastOnes = expOnes;
  endtask

  task automatic test_random(input int runIdx);
    int w;
    int cnt;
    int expEdge;
    int expOnes;
    logic [VEC_W-1:0] d;
    logic [VEC_W-1:0] wt;
    validQ.delete();
    resultQ.delete();
    w = $urandom_range(0, VALID_TMO - 2);
    for (int i = 0; i < w; i++) begin
      validQ.push_back(1'b0);
      resultQ.push_back(1'($urandom));
    end
    cnt = 0;
    while (cnt < STREAM_LEN) begin
      if (cnt == 0 || $urandom_range(0, 4) != 0) begin
        validQ.push_back(1'b1);
        cnt++;
      end else begin
        validQ.push_back(1'b0);
      end
      resultQ.push_back(1'($urandom));
    end
    // Trailing valid ones land in DONE/IDLE and must not be counted.
    for (int i = 0; i < 3; i++) begin
      validQ.push_back(1'b1);
      resultQ.push_back(1'b1);
    end
    expEdge = model_done_edge();
    expOnes = model_ones();
    d  = $urandom;
    wt = $urandom;
    drive_run(d, wt);
    checks++;
    if (obsDoneEdge !== expEdge || obsDoneCount !== 1) begin
      errors++;
      $display("[TB] FAIL rand%0d_done: got edge %0d width %0d expected edge %0d width 1",
               runIdx, obsDoneEdge, obsDoneCount, expEdge);
    end
    checks++;
    if (obsOnes !== 9'(expOnes) || obsDot !== model_dot(expOnes)) begin
      errors++;
      $display("[TB] FAIL rand%0d_result: got %0d/%0d expected %0d/%0d",
               runIdx, obsOnes, obsDot, expOnes, model_dot(expOnes));
    end
    checks++;
    if (obsOpD !== d || obsOpW !== wt) begin
      errors++;
      $display("[TB] FAIL rand%0d_ops: got %h/%h expected %h/%h", runIdx, obsOpD, obsOpW, d, wt);
    end
    lastOnes = expOnes;
  endtask

  task automatic test_timeout();
    int errEdge;
    int doneSeen;
    errEdge  = -1;
    doneSeen = 0;
    bus.datas     = $urandom;
    bus.weights   = $urandom;
    bus.dp_valid  = 1'b0;
    bus.dp_result = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= VALID_TMO + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.error === 1'b1 && errEdge < 0) errEdge = k;
      if (bus.done === 1'b1) doneSeen++;
    end
    checks++;
    if (errEdge !== VALID_TMO + 1) begin
      errors++;
      $display("[TB] FAIL tmo_edge: got %0d expected %0d", errEdge, VALID_TMO + 1);
    end
    checks++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0 || doneSeen !== 0) begin
      errors++;
      $display("[TB] FAIL tmo_state: got error=%b busy=%b dones=%0d expected 1/0/0",
               bus.error, bus.busy, doneSeen);
    end
    checks++;
    if (bus.ones_count !== 9'(lastOnes)) begin
      errors++;
      $display("[TB] FAIL tmo_kept: got %0d expected %0d", bus.ones_count, lastOnes);
    end
    validQ.delete();
    resultQ.delete();
    for (int i = 0; i < STREAM_LEN; i++) begin
      validQ.push_back(1'b1);
      resultQ.push_back(1'b1);
    end
    drive_run($urandom, $urandom);
    checks++;
    if (obsErrAfterStart !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_clear: got error=%b expected 0", obsErrAfterStart);
    end
    checks++;
    if (obsOnes !== 9'(model_ones())) begin
      errors++;
      $display("[TB] FAIL tmo_rerun: got %0d expected %0d", obsOnes, model_ones());
    end
    lastOnes = model_ones();
  endtask

  task automatic test_abort();
    logic [VEC_W-1:0] dA;
    int doneSeen;
    doneSeen      = 0;
    dA            = $urandom;
    bus.datas     = dA;
    bus.weights   = $urandom;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      bus.start     = (k == 50);
      bus.datas     = (k == 50) ? ~dA : dA;
      bus.dp_valid  = 1'b1;
      bus.dp_result = 1'b1;
      bus.abort     = (k == 101);
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneSeen++;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.src_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got busy=%b enable=%b expected 0/0", bus.busy, bus.src_enable);
    end
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneSeen++;
    end
    bus.dp_valid = 1'b0;
    checks++;
    if (doneSeen !== 0 || bus.ones_count !== 9'(lastOnes)) begin
      errors++;
      $display("[TB] FAIL abort_result: got dones=%0d ones=%0d expected 0/%0d",
               doneSeen, bus.ones_count, lastOnes);
    end
    checks++;
    if (bus.op_datas !== dA) begin
      errors++;
      $display("[TB] FAIL busy_start: got op_datas=%h expected %h", bus.op_datas, dA);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.datas   = $urandom;
    bus.weights = $urandom;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      bus.dp_valid  = 1'b1;
      bus.dp_result = 1'b1;
      if (k == 51) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.src_enable, bus.src_restart} !== 5'b0 ||
        bus.ones_count !== '0 || bus.dot_product !== '0 ||
        bus.op_datas !== '0 || bus.op_weights !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got ctrl=%b ones=%0d dot=%0d ops=%h/%h expected all 0",
               {bus.busy, bus.done, bus.error, bus.src_enable, bus.src_restart},
               bus.ones_count, bus.dot_product, bus.op_datas, bus.op_weights);
    end
    rst          = 1'b0;
    bus.dp_valid = 1'b0;
    @(posedge clk);
    #1;
    validQ.delete();
    resultQ.delete();
    for (int i = 0; i < STREAM_LEN; i++) begin
      validQ.push_back(1'b1);
      resultQ.push_back(1'b0);
    end
    drive_run($urandom, $urandom);
    checks++;
    if (obsDoneEdge !== model_done_edge() || obsOnes !== 9'(model_ones()) ||
        obsDot !== model_dot(model_ones())) begin
      errors++;
      $display("[TB] FAIL midrst_rerun: got edge %0d ones=%0d dot=%0d expected edge %0d ones=%0d dot=%0d",
               obsDoneEdge, obsOnes, obsDot, model_done_edge(), model_ones(), model_dot(model_ones()));
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    lastOnes = 0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_stall();
    for (int r = 0; r < 3; r++) test_random(r);
    test_timeout();
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a bench that stops making progress.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
